// File: rtl/hawkes_thin.sv
// Ogata thinning stage: draws a uniform variate from a Galois LFSR, scales it
// by the dominating bound and accepts/rejects the candidate event, selecting
// the event dimension from the cumulative intensities on accept.
module hawkes_thin #(
   parameter int          W    = 9,
   parameter logic [15:0] SEED = 16'hACE1,
   parameter int          CW   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [W-1:0]  lam1,
   input  logic [W-1:0]  lam2,
   input  logic [W-1:0]  lam3,
   input  logic [W-1:0]  lam4,
   input  logic [W-1:0]  lambda_bar,
   output logic          busy,
   output logic          done,
   output logic          accept,
   output logic [1:0]    k,
   output logic          bound_err,
   output logic [CW-1:0] ev_count
);

   typedef enum logic [2:0] {IDLE, DRAW, SUM, SCALE, DECIDE} state_t;

   state_t          state_q, state_d;
   logic [15:0]     lfsr_q;
   logic [W-1:0]    lam1_q, lam2_q, lam3_q, lam4_q, lb_q;
   logic [7:0]      u_q;
   logic [W+1:0]    c1_q, c2_q, c3_q, tot_q;
   logic [W-1:0]    thr_q;
   logic            accept_q, berr_q, done_q;
   logic [1:0]      k_q;
   logic [CW-1:0]   cnt_q;

   logic [15:0]     lfsr_nxt;
   logic [W+1:0]    c1_w, c2_w, c3_w, c4_w, thr_ext;
   logic [W+7:0]    prod_w;
   logic            acc_w;
   logic [1:0]      k_w;

   // Next-state logic; start is only looked at while idle so it never queues
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = DRAW;
         DRAW:    state_d = SUM;
         SUM:     state_d = SCALE;
         SCALE:   state_d = DECIDE;
         DECIDE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath arithmetic: LFSR step, cumulative sums, scaled threshold, decision
   always_comb begin
      lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
      c1_w     = {2'b00, lam1_q};
      c2_w     = c1_w + {2'b00, lam2_q};
      c3_w     = c2_w + {2'b00, lam3_q};
      c4_w     = c3_w + {2'b00, lam4_q};
      prod_w   = {{W{1'b0}}, u_q} * {8'b0, lb_q};
      thr_ext  = {2'b00, thr_q};
      acc_w    = thr_ext < tot_q;
      // First cumulative sum strictly above thr; equality falls through
      k_w      = 2'd0;
      if (acc_w) begin
         if      (c1_q > thr_ext) k_w = 2'd0;
         else if (c2_q > thr_ext) k_w = 2'd1;
         else if (c3_q > thr_ext) k_w = 2'd2;
         else                     k_w = 2'd3;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Per-state datapath registers and held decision outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q   <= SEED;
         lam1_q   <= '0;
         lam2_q   <= '0;
         lam3_q   <= '0;
         lam4_q   <= '0;
         lb_q     <= '0;
         u_q      <= '0;
         c1_q     <= '0;
         c2_q     <= '0;
         c3_q     <= '0;
         tot_q    <= '0;
         thr_q    <= '0;
         accept_q <= 1'b0;
         k_q      <= 2'd0;
         berr_q   <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               lam1_q <= lam1;
               lam2_q <= lam2;
               lam3_q <= lam3;
               lam4_q <= lam4;
               lb_q   <= lambda_bar;
            end
            DRAW: lfsr_q <= lfsr_nxt;
            SUM: begin
               u_q   <= lfsr_q[7:0];
               c1_q  <= c1_w;
               c2_q  <= c2_w;
               c3_q  <= c3_w;
               tot_q <= c4_w;
            end
            SCALE: thr_q <= prod_w[W+7:8];
            DECIDE: begin
               accept_q <= acc_w;
               k_q      <= k_w;
               berr_q   <= tot_q > {2'b00, lb_q};
               if (acc_w && (cnt_q != '1)) cnt_q <= cnt_q + CW'(1);
               done_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign accept    = accept_q;
   assign k         = k_q;
   assign bound_err = berr_q;
   assign ev_count  = cnt_q;

endmodule

// File: tb/tb_hawkes_thin.sv
// Directed bench for hawkes_thin: hand-computed LFSR draws, latency, reset,
// start-ignore and counter saturation (second instance with a 3-bit counter).
module tb_hawkes_thin;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, start2 = 1'b0;
   logic [8:0]  lam1 = '0, lam2 = '0, lam3 = '0, lam4 = '0, lb = '0;
   logic        busy, done, accept, berr;
   logic [1:0]  k;
   logic [15:0] evc;
   logic        busy2, done2, accept2, berr2;
   logic [1:0]  k2;
   logic [2:0]  evc2;
   int          tests = 0, fails = 0, done_cnt = 0;

   always #5 clk = ~clk;

   hawkes_thin #(.W(9), .SEED(16'hACE1), .CW(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .lam1(lam1), .lam2(lam2), .lam3(lam3), .lam4(lam4), .lambda_bar(lb),
      .busy(busy), .done(done), .accept(accept), .k(k),
      .bound_err(berr), .ev_count(evc));

   hawkes_thin #(.W(9), .SEED(16'hACE1), .CW(3)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .lam1(lam1), .lam2(lam2), .lam3(lam3), .lam4(lam4), .lambda_bar(lb),
      .busy(busy2), .done(done2), .accept(accept2), .k(k2),
      .bound_err(berr2), .ev_count(evc2));

   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Launch one draw, scramble inputs right after the latch, check exact latency
   task automatic draw(input string tag, input logic [8:0] a, b, c, d, bar,
                       input logic eacc, input logic [1:0] ek, input logic eberr,
                       input logic [15:0] ecnt);
      @(negedge clk);
      lam1 = a; lam2 = b; lam3 = c; lam4 = d; lb = bar; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lam1 = 9'h1FF; lam2 = 9'h1FF; lam3 = 9'h1FF; lam4 = 9'h1FF; lb = 9'h0;
      repeat (3) @(posedge clk);
      #1 chk({tag, ".done_early"}, done, 1'b0);
      @(posedge clk); #1;
      chk({tag, ".done"}, done, 1'b1);
      chk({tag, ".accept"}, accept, eacc);
      chk({tag, ".k"}, k, ek);
      chk({tag, ".bound_err"}, berr, eberr);
      chk({tag, ".ev_count"}, evc, ecnt);
   endtask

   initial begin
      int d0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.accept", accept, 1'b0);
      chk("rst.k", k, 2'd0);
      chk("rst.ev_count", evc, 16'd0);
      @(negedge clk) rst_n = 1'b1;

      // 1/2: LFSR E270 -> u=112 thr=112, then 7138 -> u=56 thr=56 tot=48
      draw("s1", 9'd64, 9'd32, 9'd16, 9'd16, 9'h100, 1'b1, 2'd3, 1'b0, 16'd1);
      draw("s2", 9'd16, 9'd16, 9'd16, 9'd0,  9'h100, 1'b0, 2'd0, 1'b0, 16'd1);

      // 3: zero intensity rejects; bound violation flagged without changing accept
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      draw("s3a", 9'd0, 9'd0, 9'd0, 9'd0, 9'h1FF, 1'b0, 2'd0, 1'b0, 16'd0);
      draw("s3b", 9'd200, 9'd200, 9'd0, 9'd0, 9'd100, 1'b1, 2'd0, 1'b1, 16'd1);

      // 4: start re-pulsed during DRAW is ignored; LFSR advances only once
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      d0 = done_cnt;
      @(negedge clk);
      lam1 = 9'd64; lam2 = 9'd32; lam3 = 9'd16; lam4 = 9'd16; lb = 9'h100; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      chk("s4.busy_draw", busy, 1'b1);
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("s4.done", done, 1'b1);
      chk("s4.accept", accept, 1'b1);
      chk("s4.k", k, 2'd3);
      repeat (10) @(posedge clk);
      #1 chk("s4.one_done", done_cnt - d0, 1);
      draw("s4b", 9'd16, 9'd16, 9'd16, 9'd0, 9'h100, 1'b0, 2'd0, 1'b0, 16'd1);

      // 5: asynchronous reset while in SCALE clears everything with no done
      @(negedge clk);
      lam1 = 9'd64; lam2 = 9'd32; lam3 = 9'd16; lam4 = 9'd16; lb = 9'h100; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("s5.busy_scale", busy, 1'b1);
      d0 = done_cnt;
      #2 rst_n = 1'b0;
      #1;
      chk("s5.busy", busy, 1'b0);
      chk("s5.ev_count", evc, 16'd0);
      chk("s5.accept", accept, 1'b0);
      chk("s5.k", k, 2'd0);
      chk("s5.bound_err", berr, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1 chk("s5.no_done", done_cnt - d0, 0);
      draw("s5b", 9'd64, 9'd32, 9'd16, 9'd16, 9'h100, 1'b1, 2'd3, 1'b0, 16'd1);

      // 6: 3-bit counter saturates at 7; tot=1020 always beats thr<=255
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         lam1 = 9'd255; lam2 = 9'd255; lam3 = 9'd255; lam4 = 9'd255; lb = 9'h100;
         start2 = 1'b1;
         @(posedge clk); #1 start2 = 1'b0;
         repeat (4) @(posedge clk);
         #1;
         chk($sformatf("s6.done%0d", i), done2, 1'b1);
         chk($sformatf("s6.accept%0d", i), accept2, 1'b1);
         chk($sformatf("s6.cnt%0d", i), evc2, (i > 7) ? 3'd7 : 3'(i));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
